ls_mem_arbiter: RTL and testbench

Single-clock load/store arbiter between the two cores' data-memory request ports and the shared memory's load/store port pair, running in the sys_clk domain. It serves one outstanding transaction at a time. Grants are round-robin between cores. It drives exactly one memory enable pulse per grant and returns the memory response to the granted core. An optional timeout completes a transaction with an error if memory never answers.

---
 rtl/ls_mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_ls_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_mem_arbiter.sv
// Purpose: round-robin load/store arbiter, two cores onto one shared memory port pair, one transaction in flight.
// Latency: request sampled at edge N -> mem enable in cycle N+1 -> resp_valid one cycle after the matching memory valid (min 3 cycles).
// Backpressure: cores hold req_ld/req_st as levels until they see resp_valid; memory is waited on indefinitely unless ARB_TIMEOUT_EN.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_ld/req_st/req_adrs/req_wdata   per-core request levels, address and store data (core i in slice i)
//   resp_valid/resp_data/resp_err      one-cycle completion pulse per core, shared load data, timeout flag
//   mem_r_* / mem_w_*        shared memory load and store ports
// Optional feature: define ARB_TIMEOUT_EN to add the WAIT-state timeout with error completion.

module ls_mem_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_ld,
    input  logic [1:0]            req_st,
    input  logic [2*ADDR_W-1:0]   req_adrs,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            resp_valid,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  resp_err,
    output logic                  mem_r_en,
    output logic [ADDR_W-1:0]     mem_r_adrs,
    input  logic                  mem_r_valid,
    input  logic [DATA_W-1:0]     mem_r_data,
    output logic                  mem_w_en,
    output logic [ADDR_W-1:0]     mem_w_adrs,
    output logic [DATA_W-1:0]     mem_w_data,
    input  logic                  mem_w_valid
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;        // granted core id
    logic                op_st_q, op_st_d;    // 1 = store, 0 = load
    logic [ADDR_W-1:0]   adrs_q, adrs_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;    // completion data waiting for RESP
    logic                last_q, last_d;      // last granted core
    logic [1:0]          mask_q, mask_d;      // served core, blocked for one IDLE cycle

    logic [1:0]          resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                mem_r_en_q, mem_r_en_d;
    logic                mem_w_en_q, mem_w_en_d;
    logic [ADDR_W-1:0]   mem_r_adrs_q, mem_r_adrs_d;
    logic [ADDR_W-1:0]   mem_w_adrs_q, mem_w_adrs_d;
    logic [DATA_W-1:0]   mem_w_data_q, mem_w_data_d;

    logic [1:0]          elig;
    logic                sel;
    logic                match;

`ifdef ARB_TIMEOUT_EN
    // Counter only needs to reach TIMEOUT-1: the count after a WAIT cycle is cnt_q+1,
    // so reaching TIMEOUT means cnt_q == TIMEOUT-1 during that cycle.
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                resp_err_q, resp_err_d;
`else
    logic                unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign elig  = (req_ld | req_st) & ~mask_q;
    // On a tie the core that was not granted last wins; otherwise the single eligible core.
    assign sel   = (elig == 2'b11) ? ~last_q : elig[1];
    // Only the valid belonging to the issued op can complete the transaction.
    assign match = op_st_q ? mem_w_valid : mem_r_valid;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        op_st_d      = op_st_q;
        adrs_d       = adrs_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        last_d       = last_q;
        mask_d       = mask_q;
        resp_valid_d = 2'b00;
        resp_data_d  = resp_data_q;
        mem_r_en_d   = 1'b0;
        mem_w_en_d   = 1'b0;
        mem_r_adrs_d = mem_r_adrs_q;
        mem_w_adrs_d = mem_w_adrs_q;
        mem_w_data_d = mem_w_data_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
        resp_err_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                mask_d = 2'b00;
                if (elig != 2'b00) begin
                    gnt_d   = sel;
                    // Store wins when both are raised; the held load gets a later grant.
                    op_st_d = req_st[sel];
                    adrs_d  = sel ? req_adrs[2*ADDR_W-1:ADDR_W]  : req_adrs[ADDR_W-1:0];
                    wdata_d = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_r_en_d   = ~op_st_q;
                mem_w_en_d   = op_st_q;
                mem_r_adrs_d = adrs_q;
                mem_w_adrs_d = adrs_q;
                mem_w_data_d = wdata_q;
                last_d       = gnt_q;
                state_d      = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
                cnt_d        = '0;
`endif
            end
            ST_WAIT: begin
                if (match) begin
                    rdata_d = op_st_q ? '0 : mem_r_data;
                    state_d = ST_RESP;
`ifdef ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            ST_RESP: begin
                resp_valid_d = {gnt_q, ~gnt_q};
                resp_data_d  = rdata_q;
                mask_d       = {gnt_q, ~gnt_q};
                state_d      = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
                resp_err_d   = err_q;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 1'b0;
            op_st_q      <= 1'b0;
            adrs_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            last_q       <= 1'b1;
            mask_q       <= 2'b00;
            resp_valid_q <= 2'b00;
            resp_data_q  <= '0;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            mem_r_adrs_q <= '0;
            mem_w_adrs_q <= '0;
            mem_w_data_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            op_st_q      <= op_st_d;
            adrs_q       <= adrs_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            last_q       <= last_d;
            mask_q       <= mask_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mem_r_en_q   <= mem_r_en_d;
            mem_w_en_q   <= mem_w_en_d;
            mem_r_adrs_q <= mem_r_adrs_d;
            mem_w_adrs_q <= mem_w_adrs_d;
            mem_w_data_q <= mem_w_data_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign mem_r_en   = mem_r_en_q;
    assign mem_w_en   = mem_w_en_q;
    assign mem_r_adrs = mem_r_adrs_q;
    assign mem_w_adrs = mem_w_adrs_q;
    assign mem_w_data = mem_w_data_q;
`ifdef ARB_TIMEOUT_EN
    assign resp_err   = resp_err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ls_mem_arbiter.sv
// Purpose: directed self-checking bench for ls_mem_arbiter.
// Latency: checks request-to-enable and valid-to-response cycle positions.
// Backpressure: models cores holding requests and memory answering late or never.

module tb_ls_mem_arbiter;
    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic                clk;
    logic                rst;
    logic [1:0]          req_ld;
    logic [1:0]          req_st;
    logic [2*ADDR_W-1:0] req_adrs;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          resp_valid;
    logic [DATA_W-1:0]   resp_data;
    logic                resp_err;
    logic                mem_r_en;
    logic [ADDR_W-1:0]   mem_r_adrs;
    logic                mem_r_valid;
    logic [DATA_W-1:0]   mem_r_data;
    logic                mem_w_en;
    logic [ADDR_W-1:0]   mem_w_adrs;
    logic [DATA_W-1:0]   mem_w_data;
    logic                mem_w_valid;

    int total = 0;
    int bad   = 0;

    ls_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_ld(req_ld), .req_st(req_st), .req_adrs(req_adrs), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_r_en(mem_r_en), .mem_r_adrs(mem_r_adrs), .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data),
        .mem_w_en(mem_w_en), .mem_w_adrs(mem_w_adrs), .mem_w_data(mem_w_data), .mem_w_valid(mem_w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;
        rst = 1'b1; req_ld = 2'b00; req_st = 2'b00; req_adrs = '0; req_wdata = '0;
        mem_r_valid = 1'b0; mem_r_data = '0; mem_w_valid = 1'b0;
        step(); step();

        // Reset state
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_mem_r_en",   64'(mem_r_en),   64'(0));
        chk("rst_mem_w_en",   64'(mem_w_en),   64'(0));

        // Core 0 load at 0x005, memory answers one cycle after the enable cycle
        rst = 1'b0; req_ld = 2'b01; req_adrs = {11'h000, 11'h005};
        step();
        chk("ld_no_en_yet", 64'(mem_r_en), 64'(0));
        step();
        chk("ld_r_en",   64'(mem_r_en),   64'(1));
        chk("ld_r_adrs", 64'(mem_r_adrs), 64'(11'h005));
        chk("ld_w_en",   64'(mem_w_en),   64'(0));
        step();
        chk("ld_r_en_once", 64'(mem_r_en), 64'(0));
        mem_r_valid = 1'b1; mem_r_data = 32'hDEADBEEF;
        step();
        mem_r_valid = 1'b0; mem_r_data = '0;
        chk("ld_no_resp_early", 64'(resp_valid), 64'(0));
        step();
        chk("ld_resp_valid", 64'(resp_valid), 64'(2'b01));
        chk("ld_resp_data",  64'(resp_data),  64'(32'hDEADBEEF));
        chk("ld_resp_err",   64'(resp_err),   64'(0));
        req_ld = 2'b00;
        step();
        chk("ld_resp_pulse", 64'(resp_valid), 64'(0));
        chk("ld_data_hold",  64'(resp_data),  64'(32'hDEADBEEF));

        // Tie of stores after reset: core 0 first, then strict alternation
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_st = 2'b11; req_adrs = {11'h020, 11'h010}; req_wdata = {32'hB1B1B1B1, 32'hA0A0A0A0};
        mem_w_valid = 1'b1;   // held high: only WAIT may take it
        for (int t = 0; t < 8; t++) begin
            logic c;
            c = t[0];
            step();
            chk("rr_grant_no_en", 64'(mem_w_en),   64'(0));
            chk("rr_grant_no_rv", 64'(resp_valid), 64'(0));
            step();
            chk("rr_w_en",   64'(mem_w_en),   64'(1));
            chk("rr_w_adrs", 64'(mem_w_adrs), c ? 64'(11'h020) : 64'(11'h010));
            chk("rr_w_data", 64'(mem_w_data), c ? 64'(32'hB1B1B1B1) : 64'(32'hA0A0A0A0));
            step();
            chk("rr_w_en_once", 64'(mem_w_en), 64'(0));
            step();
            chk("rr_resp_valid", 64'(resp_valid), c ? 64'(2'b10) : 64'(2'b01));
            chk("rr_resp_data",  64'(resp_data),  64'(0));
            if (t == 7) begin
                req_st = 2'b00; mem_w_valid = 1'b0;
            end
        end
        step();

        // Core 1 store to 0x7FF; a load valid during WAIT must not complete it
        req_st = 2'b10; req_adrs = {11'h7FF, 11'h000}; req_wdata = {32'h12345678, 32'h0};
        step();
        chk("st_no_en_yet", 64'(mem_w_en), 64'(0));
        step();
        chk("st_w_en",   64'(mem_w_en),   64'(1));
        chk("st_w_adrs", 64'(mem_w_adrs), 64'(11'h7FF));
        chk("st_w_data", 64'(mem_w_data), 64'(32'h12345678));
        chk("st_r_en",   64'(mem_r_en),   64'(0));
        mem_r_valid = 1'b1; mem_r_data = 32'hFFFFFFFF;
        step();
        mem_r_valid = 1'b0; mem_r_data = '0;
        chk("st_w_en_once", 64'(mem_w_en), 64'(0));
        step();
        chk("st_wrong_valid_ignored", 64'(resp_valid), 64'(0));
        mem_w_valid = 1'b1;
        step();
        mem_w_valid = 1'b0;
        chk("st_no_resp_early", 64'(resp_valid), 64'(0));
        chk("st_no_second_en",  64'(mem_w_en),   64'(0));
        step();
        chk("st_resp_valid", 64'(resp_valid), 64'(2'b10));
        chk("st_resp_data",  64'(resp_data),  64'(0));
        chk("st_resp_err",   64'(resp_err),   64'(0));
        req_st = 2'b00;
        step();

        // Core 0 load at 0x123, memory silent
        req_ld = 2'b01; req_adrs = {11'h000, 11'h123};
        step();
        step();
        chk("to_r_en",   64'(mem_r_en),   64'(1));
        chk("to_r_adrs", 64'(mem_r_adrs), 64'(11'h123));
        seen = 1'b0;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            if (resp_valid != 2'b00) seen = 1'b1;
        end
        chk("to_silent_before_limit", 64'(seen), 64'(0));
        step();
        chk("to_resp_valid", 64'(resp_valid), 64'(2'b01));
        chk("to_resp_err",   64'(resp_err),   64'(1));
        chk("to_resp_data",  64'(resp_data),  64'(0));
`else
        for (int i = 0; i < 100; i++) begin
            step();
            if (resp_valid != 2'b00 || mem_r_en || mem_w_en) seen = 1'b1;
        end
        chk("wait_holds_100", 64'(seen), 64'(0));
        mem_r_valid = 1'b1; mem_r_data = 32'hCAFEF00D;
        step();
        mem_r_valid = 1'b0; mem_r_data = '0;
        chk("late_no_resp_early", 64'(resp_valid), 64'(0));
        step();
        chk("late_resp_valid", 64'(resp_valid), 64'(2'b01));
        chk("late_resp_data",  64'(resp_data),  64'(32'hCAFEF00D));
        chk("late_resp_err",   64'(resp_err),   64'(0));
`endif
        req_ld = 2'b00;
        step();

        // Reset in WAIT of a core 1 load, then a late load valid
        req_ld = 2'b10; req_adrs = {11'h0AA, 11'h000};
        step();
        step();
        chk("rw_r_en",   64'(mem_r_en),   64'(1));
        chk("rw_r_adrs", 64'(mem_r_adrs), 64'(11'h0AA));
        step();
        rst = 1'b1; req_ld = 2'b00;
        step();
        rst = 1'b0;
        chk("rw_resp_valid", 64'(resp_valid), 64'(0));
        chk("rw_resp_data",  64'(resp_data),  64'(0));
        chk("rw_resp_err",   64'(resp_err),   64'(0));
        chk("rw_mem_r_en",   64'(mem_r_en),   64'(0));
        chk("rw_mem_w_en",   64'(mem_w_en),   64'(0));
        chk("rw_mem_r_adrs", 64'(mem_r_adrs), 64'(0));
        chk("rw_mem_w_adrs", 64'(mem_w_adrs), 64'(0));
        chk("rw_mem_w_data", 64'(mem_w_data), 64'(0));
        mem_r_valid = 1'b1; mem_r_data = 32'h00000001;
        step();
        mem_r_valid = 1'b0; mem_r_data = '0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (resp_valid != 2'b00 || mem_r_en) seen = 1'b1;
        end
        chk("rw_late_valid_ignored", 64'(seen), 64'(0));
        req_ld = 2'b11; req_adrs = {11'h222, 11'h111};
        step();
        step();
        chk("rw_tie_r_en",   64'(mem_r_en),   64'(1));
        chk("rw_tie_core0",  64'(mem_r_adrs), 64'(11'h111));
        mem_r_valid = 1'b1; mem_r_data = 32'h55AA55AA;
        step();
        mem_r_valid = 1'b0; mem_r_data = '0;
        step();
        chk("rw_tie_resp_valid", 64'(resp_valid), 64'(2'b01));
        chk("rw_tie_resp_data",  64'(resp_data),  64'(32'h55AA55AA));
        req_ld = 2'b00;
        step();

        // Core 0 raises load and store together: store first, load on the next grant
        req_ld = 2'b01; req_st = 2'b01; req_adrs = {11'h000, 11'h333}; req_wdata = {32'h0, 32'h00000077};
        step();
        step();
        chk("ls_w_en_first", 64'(mem_w_en),   64'(1));
        chk("ls_r_en_first", 64'(mem_r_en),   64'(0));
        chk("ls_w_adrs",     64'(mem_w_adrs), 64'(11'h333));
        chk("ls_w_data",     64'(mem_w_data), 64'(32'h00000077));
        mem_w_valid = 1'b1;
        step();
        mem_w_valid = 1'b0;
        step();
        chk("ls_st_resp", 64'(resp_valid), 64'(2'b01));
        req_st = 2'b00;
        step();
        chk("ls_masked_idle", 64'(mem_r_en), 64'(0));
        step();
        chk("ls_issue_no_en", 64'(mem_r_en), 64'(0));
        step();
        chk("ls_r_en_second", 64'(mem_r_en),   64'(1));
        chk("ls_r_adrs",      64'(mem_r_adrs), 64'(11'h333));
        mem_r_valid = 1'b1; mem_r_data = 32'h00000099;
        step();
        mem_r_valid = 1'b0; mem_r_data = '0;
        step();
        chk("ls_ld_resp",      64'(resp_valid), 64'(2'b01));
        chk("ls_ld_resp_data", 64'(resp_data),  64'(32'h00000099));
        req_ld = 2'b00;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
